// File: rtl/cpu_defs.sv
// Shared CPU types: instruction opcodes, load/store unit states and the data-bus request bundle.
package cpu_defs;

    typedef enum logic [4:0] {
        OpNop, OpLb, OpLbu, OpLh, OpLhu, OpLw, OpLl, OpLwc1, OpLwl, OpLwr,
        OpSb, OpSh, OpSw, OpSc, OpSwl, OpSwr, OpSwc1
    } Oper_t;

    typedef enum logic [2:0] {StIdle, StReq, StWait, StDrain, StDone} LsuState_t;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } DBusReq_t;

endpackage

// File: rtl/cpu_mem_access_if.sv
// Request/grant/response data bus between the memory-access stage and the data memory.
interface cpu_mem_access_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/cpu_mem_access_align.sv
// Load result formatter: picks, extends and merges bus read data into the final register value.
module mem_load_align
    import cpu_defs::*;
(
    input  Oper_t       op,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [31:0] rt,
    output logic [31:0] word
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{offset, 3'b000} +: 8];
    assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        word = '0;
        case (op)
            OpLb:               word = {{24{byte_sel[7]}}, byte_sel};
            OpLbu:              word = {24'h0, byte_sel};
            OpLh:               word = {{16{half_sel[15]}}, half_sel};
            OpLhu:              word = {16'h0, half_sel};
            OpLw, OpLl, OpLwc1: word = rdata;
            OpLwl: begin
                unique case (offset)
                    2'd0: word = {rdata[7:0], rt[23:0]};
                    2'd1: word = {rdata[15:0], rt[15:0]};
                    2'd2: word = {rdata[23:0], rt[7:0]};
                    2'd3: word = rdata;
                endcase
            end
            OpLwr: begin
                unique case (offset)
                    2'd0: word = rdata;
                    2'd1: word = {rt[31:24], rdata[31:8]};
                    2'd2: word = {rt[31:16], rdata[31:16]};
                    2'd3: word = {rt[31:8], rdata[31:24]};
                endcase
            end
            // The write ack of a store-conditional means the store went through.
            OpSc:               word = 32'd1;
            default:            word = '0;
        endcase
    end
endmodule

// File: rtl/cpu_mem_access.sv
// Memory-access stage load/store unit: one bus transaction per op, stalling the pipe until done.
module cpu_mem_access
    import cpu_defs::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              pipe_stall,
    input  logic              mem_ce,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [3:0]        mem_sel,
    input  logic [31:0]       mem_wdata,
    input  Oper_t             op,
    input  logic [31:0]       reg2,
    input  logic              llbit,
    input  logic              except_any,
    cpu_mem_access_if.master  dbus,
    output logic              stall_req,
    output logic              rdata_valid,
    output logic [31:0]       load_data
);
    LsuState_t   state_q;
    DBusReq_t    bus_q;
    Oper_t       op_q;
    logic [31:0] rt_q;
    logic [1:0]  off_q;
    logic [31:0] load_data_q;
    logic        rdata_valid_q;
    logic [31:0] aligned;
    logic        eff_op;

    assign eff_op = mem_ce & ~except_any & ~flush;

    mem_load_align u_align (
        .op     (op_q),
        .offset (off_q),
        .rdata  (dbus.rdata),
        .rt     (rt_q),
        .word   (aligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            bus_q         <= '0;
            op_q          <= OpNop;
            rt_q          <= '0;
            off_q         <= '0;
            load_data_q   <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (eff_op) begin
                        op_q  <= op;
                        rt_q  <= reg2;
                        off_q <= mem_addr[1:0];
                        // A store-conditional with a lost link never touches the bus.
                        if (op == OpSc && !llbit) begin
                            load_data_q   <= '0;
                            rdata_valid_q <= 1'b1;
                            state_q       <= StDone;
                        end else begin
                            bus_q <= '{req:   1'b1,
                                       we:    mem_we,
                                       addr:  32'({mem_addr[ADDR_W-1:2], 2'b00}),
                                       be:    mem_sel,
                                       wdata: mem_wdata};
                            state_q <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (dbus.gnt) begin
                        bus_q.req <= 1'b0;
                        state_q   <= flush ? StDrain : StWait;
                    end else if (flush) begin
                        bus_q.req <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                StWait: begin
                    if (dbus.rvalid) begin
                        if (flush) begin
                            state_q <= StIdle;
                        end else begin
                            load_data_q   <= aligned;
                            rdata_valid_q <= 1'b1;
                            state_q       <= StDone;
                        end
                    end else if (flush) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (dbus.rvalid) state_q <= StIdle;
                end
                StDone: begin
                    if (flush || !pipe_stall) begin
                        rdata_valid_q <= 1'b0;
                        state_q       <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dbus.req    = bus_q.req;
    assign dbus.we     = bus_q.we;
    assign dbus.addr   = bus_q.addr[ADDR_W-1:0];
    assign dbus.be     = bus_q.be;
    assign dbus.wdata  = bus_q.wdata;
    assign load_data   = load_data_q;
    assign rdata_valid = rdata_valid_q;

    // A new op arriving during a drain waits until the abandoned response is swallowed.
    assign stall_req = ~rst & ((state_q == StIdle && eff_op) || state_q == StReq ||
                               state_q == StWait || (state_q == StDrain && mem_ce));
endmodule
